// File: rtl/serdes_pkg.sv
// Shared definitions for the serial receive path: lock-FSM state encodings,
// default 8b/10b comma constants and small counter helpers used by
// ser2par_align and its shift/compare sub-module.
package serdes_pkg;

    // Lock state machine encodings; also exported on the state debug output.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // K28.5 in both running disparities, first-transmitted bit in bit 9.
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    // Width of the hit/miss counters; thresholds are limited to 1..15.
    localparam int CNT_W = 4;

    // Saturating increment for the hit/miss counters so a long run can
    // never wrap back below a threshold.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = v;
        if (v != {CNT_W{1'b1}}) begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ser2par_align_if.sv
// Bundle of the serial input and aligned parallel output of ser2par_align.
// Optional error-counter signals exist only when SER2PAR_ALIGN_ERRCNT_EN is
// defined.
//
// Handshake: out_valid is a one-cycle pulse with no back-pressure (there is
// no ready). The consumer must take out_par/out_comma in the cycle out_valid
// is high; out_comma is only meaningful while out_valid is high. out_par
// holds its last value between pulses. inp_ser/neg are sampled every clock.
interface ser2par_align_if #(
    parameter int WIDTH = 10
) ();

    logic             inp_ser;
    logic             neg;
    logic [WIDTH-1:0] out_par;
    logic             out_valid;
    logic             out_comma;
    logic             locked;
    logic [1:0]       state;
`ifdef SER2PAR_ALIGN_ERRCNT_EN
    logic [15:0]      err_cnt;
    logic             err_clr;
`endif

`ifdef SER2PAR_ALIGN_ERRCNT_EN
    // Stimulus side: drives the serial stream, observes aligned words.
    modport master (
        output inp_ser, output neg, output err_clr,
        input  out_par, input out_valid, input out_comma,
        input  locked, input state, input err_cnt
    );
    // Receiver side: the ser2par_align block itself.
    modport slave (
        input  inp_ser, input neg, input err_clr,
        output out_par, output out_valid, output out_comma,
        output locked, output state, output err_cnt
    );
`else
    // Stimulus side: drives the serial stream, observes aligned words.
    modport master (
        output inp_ser, output neg,
        input  out_par, input out_valid, input out_comma,
        input  locked, input state
    );
    // Receiver side: the ser2par_align block itself.
    modport slave (
        input  inp_ser, input neg,
        output out_par, output out_valid, output out_comma,
        output locked, output state
    );
`endif

endinterface

// File: rtl/ser2par_align_shift.sv
// ser2par_shift: polarity correction, WIDTH-bit shift register and comma
// comparator. The window presented to the FSM is the next-state value of the
// shift register, so a comma is recognised in the same cycle its last bit is
// sampled.
module ser2par_shift #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] COMMA     = WIDTH'(serdes_pkg::K28_5_RDN),
    parameter int               MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] window_o,
    output logic             comma_o
);

    logic             bit_in;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Inversion applies only to the bit being sampled now; stored bits keep
    // the polarity they were captured with.
    assign bit_in = ser_i ^ neg_i;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            // Oldest bit ends up in the MSB after WIDTH shifts.
            assign shift_d = {shift_q[WIDTH-2:0], bit_in};
        end else begin : g_lsb_first
            // Oldest bit ends up in the LSB after WIDTH shifts.
            assign shift_d = {bit_in, shift_q[WIDTH-1:1]};
        end
    endgenerate

    // Shift register, cleared by reset so a partial word is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign window_o = shift_d;
    assign comma_o  = (shift_d == COMMA);

endmodule

// File: rtl/ser2par_align.sv
// ser2par_align: serial-to-parallel converter with comma-based word
// alignment and a HUNT/CHECK/LOCKED lock state machine with loss-of-lock
// detection. Words are emitted only while LOCKED, one clock after the last
// bit of the word is sampled.
//
// Optional feature macro: SER2PAR_ALIGN_ERRCNT_EN adds a 16-bit saturating
// count of off-boundary commas seen while LOCKED (err_cnt) and a synchronous
// clear (err_clr) to the interface.
module ser2par_align
    import serdes_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] COMMA     = WIDTH'(K28_5_RDN),
    parameter int               MSB_FIRST = 1,
    parameter int               LOCK_CNT  = 3,
    parameter int               LOSS_CNT  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ser2par_align_if.slave bus
);

    localparam int                   BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]     LOCK_THR = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]     LOSS_THR = CNT_W'(LOSS_CNT);

    logic [WIDTH-1:0] window;
    logic             comma_now;
    logic             boundary;
    logic             miss_event;

    state_e           state_q, state_d;
    logic [BIT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [WIDTH-1:0] out_par_q, out_par_d;
    logic             out_valid_q, out_valid_d;
    logic             out_comma_q, out_comma_d;

    ser2par_shift #(
        .WIDTH     (WIDTH),
        .COMMA     (COMMA),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .ser_i    (bus.inp_ser),
        .neg_i    (bus.neg),
        .window_o (window),
        .comma_o  (comma_now)
    );

    // The bit just sampled is the last bit of a word in the current phase.
    assign boundary = (cnt_q == LAST_BIT);

    // Next-state logic: bit counter phase, lock FSM, hit/miss counters and
    // the output word capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = boundary ? '0 : cnt_q + BIT_W'(1);
        hits_d      = hits_q;
        miss_d      = miss_q;
        out_par_d   = out_par_q;
        out_valid_d = 1'b0;
        out_comma_d = 1'b0;
        miss_event  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (comma_now) begin
                    // Realign: this cycle becomes the end of a word.
                    cnt_d  = '0;
                    hits_d = CNT_W'(1);
                    miss_d = '0;
                    state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (comma_now) begin
                    if (boundary) begin
                        hits_d = cnt_inc(hits_q);
                        if (cnt_inc(hits_q) == LOCK_THR) begin
                            state_d = ST_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        // Comma in a new phase: restart confirmation there.
                        cnt_d  = '0;
                        hits_d = CNT_W'(1);
                    end
                end
            end

            ST_LOCKED: begin
                // A boundary comma is never a miss, so it is tested first.
                if (boundary) begin
                    out_par_d   = window;
                    out_valid_d = 1'b1;
                    out_comma_d = comma_now;
                    if (comma_now) begin
                        miss_d = '0;
                    end
                end else if (comma_now) begin
                    // Off-phase comma: counted, but the phase is kept.
                    miss_event = 1'b1;
                    miss_d     = cnt_inc(miss_q);
                    if (cnt_inc(miss_q) == LOSS_THR) begin
                        state_d = ST_HUNT;
                        hits_d  = '0;
                        miss_d  = '0;
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
                hits_d  = '0;
                miss_d  = '0;
            end
        endcase
    end

    // State, counters and output registers; reset drops everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            cnt_q       <= '0;
            hits_q      <= '0;
            miss_q      <= '0;
            out_par_q   <= '0;
            out_valid_q <= 1'b0;
            out_comma_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hits_q      <= hits_d;
            miss_q      <= miss_d;
            out_par_q   <= out_par_d;
            out_valid_q <= out_valid_d;
            out_comma_q <= out_comma_d;
        end
    end

    assign bus.out_par   = out_par_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_comma = out_comma_q;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.state     = state_q;

`ifdef SER2PAR_ALIGN_ERRCNT_EN
    logic [15:0] err_q, err_d;

    // Error count: cleared while hunting, so the final count before a loss
    // of lock stays readable for the first HUNT cycle and is zero after.
    always_comb begin
        err_d = err_q;
        if (bus.err_clr || (state_q == ST_HUNT)) begin
            err_d = '0;
        end else if (miss_event && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    // Error count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_cnt = err_q;
`endif

endmodule

// File: tb/tb_ser2par_align.sv
// Directed bench for ser2par_align: a table of words for a 10-bit MSB-first
// instance (lock, inversion, slip in CHECK, loss of lock, re-lock) followed by
// hand-written sequences for a mid-word reset and an 8-bit LSB-first instance.
module tb_ser2par_align;
    import serdes_pkg::*;

    localparam logic [9:0] C10 = 10'h0FA;  // K28.5 RD-
    localparam logic [9:0] NC10 = 10'h305; // bitwise inverse of C10
    localparam logic [9:0] P10 = 10'h155;

    typedef struct {
        logic        do_rst;
        logic [9:0]  word;
        int          nbits;
        logic        neg;
        logic [1:0]  exp_state;
        logic        exp_valid;
        logic [9:0]  exp_par;
        logic        exp_comma;
        logic [15:0] exp_err;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ser2par_align_if #(.WIDTH(10)) bus_a ();
    ser2par_align_if #(.WIDTH(8))  bus_b ();

    ser2par_align #(
        .WIDTH(10), .COMMA(10'b0011111010), .MSB_FIRST(1),
        .LOCK_CNT(3), .LOSS_CNT(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    ser2par_align #(
        .WIDTH(8), .COMMA(8'hBC), .MSB_FIRST(0),
        .LOCK_CNT(3), .LOSS_CNT(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_checks = 0;
    int n_errs = 0;
    vec_t vecs[$];
    logic [7:0] exp_q[$];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [9:0] w, input int n,
                                input logic nv, input logic [1:0] st, input logic v,
                                input logic [9:0] par, input logic cm, input logic [15:0] err);
        vec_t x;
        x.do_rst = r;   x.word = w;         x.nbits = n;       x.neg = nv;
        x.exp_state = st; x.exp_valid = v;  x.exp_par = par;   x.exp_comma = cm;
        x.exp_err = err;
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        bus_a.inp_ser = 1'b0; bus_a.neg = 1'b0;
        bus_b.inp_ser = 1'b0; bus_b.neg = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Sends w[n-1:0] to instance A, oldest bit first (w[n-1]).
    task automatic send_a(input logic [9:0] w, input int n, input logic nv);
        for (int i = n - 1; i >= 0; i--) begin
            bus_a.inp_ser = w[i];
            bus_a.neg = nv;
            bus_b.inp_ser = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Sends w[7:0] to instance B, oldest bit first (w[0]).
    task automatic send_b(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            bus_b.inp_ser = w[i];
            bus_a.inp_ser = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one word to B bit by bit, checking the valid pulse position and
    // popping the scoreboard when a word appears.
    task automatic stream_b(input logic [7:0] w, input logic exp_cm, input string tag);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            bus_b.inp_ser = w[i];
            bus_a.inp_ser = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("%s_valid_bit%0d", tag, i), 32'(bus_b.out_valid), 32'(i == 7));
            if (bus_b.out_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_unexpected_word", tag), 32'(bus_b.out_par), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_par", tag), 32'(bus_b.out_par), 32'(e));
                    check($sformatf("%s_comma", tag), 32'(bus_b.out_comma), 32'(exp_cm));
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int junk;
        vec_t v;

`ifdef SER2PAR_ALIGN_ERRCNT_EN
        bus_a.err_clr = 1'b0;
        bus_b.err_clr = 1'b0;
`endif
        apply_reset();

        // Reset state of both instances.
        check("rst_a_state", 32'(bus_a.state), 32'(ST_HUNT));
        check("rst_a_locked", 32'(bus_a.locked), 32'd0);
        check("rst_a_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_a_par", 32'(bus_a.out_par), 32'd0);
        check("rst_b_state", 32'(bus_b.state), 32'(ST_HUNT));
        check("rst_b_par", 32'(bus_b.out_par), 32'd0);

        junk = $urandom_range(1, 9);

        // Lock with a random leading offset, then data and an in-phase comma.
        vecs.push_back(mk(1, 10'h000, junk, 0, ST_HUNT,   0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_LOCKED, 0, 10'h000, 0, 0));
        vecs.push_back(mk(0, P10,  10, 0, ST_LOCKED, 1, P10,     0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_LOCKED, 1, C10,     1, 0));
        // Inverted line: neg=1 with inverted comma and inverted 0x2AA.
        vecs.push_back(mk(1, 10'h00F, 4, 1, ST_HUNT,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, NC10, 10, 1, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, NC10, 10, 1, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, NC10, 10, 1, ST_LOCKED, 0, 10'h000, 0, 0));
        vecs.push_back(mk(0, P10,  10, 1, ST_LOCKED, 1, 10'h2AA, 0, 0));
        // Slip in CHECK: one extra bit after two commas restarts the count.
        vecs.push_back(mk(1, 10'h000, 2, 0, ST_HUNT,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, 10'h000, 1, 0, ST_CHECK, 0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h000, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_LOCKED, 0, 10'h000, 0, 0));
        vecs.push_back(mk(0, P10,  10, 0, ST_LOCKED, 1, P10,     0, 0));
        // Loss of lock: commas shifted by 3 bits; boundary words are rotations.
        vecs.push_back(mk(0, 10'h000, 3, 0, ST_LOCKED, 0, P10,   0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_LOCKED, 0, 10'h01F, 0, 1));
        vecs.push_back(mk(0, C10,  10, 0, ST_LOCKED, 0, 10'h11F, 0, 2));
        vecs.push_back(mk(0, C10,  10, 0, ST_LOCKED, 0, 10'h11F, 0, 3));
        vecs.push_back(mk(0, C10,  10, 0, ST_HUNT,   0, 10'h11F, 0, 4));
        // Re-lock on the shifted phase.
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h11F, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_CHECK,  0, 10'h11F, 0, 0));
        vecs.push_back(mk(0, C10,  10, 0, ST_LOCKED, 0, 10'h11F, 0, 0));
        vecs.push_back(mk(0, P10,  10, 0, ST_LOCKED, 1, P10,     0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.do_rst) apply_reset();
            send_a(v.word, v.nbits, v.neg);
            check($sformatf("v%0d_state", i), 32'(bus_a.state), 32'(v.exp_state));
            check($sformatf("v%0d_locked", i), 32'(bus_a.locked), 32'(v.exp_state == ST_LOCKED));
            check($sformatf("v%0d_valid", i), 32'(bus_a.out_valid), 32'(v.exp_valid));
            check($sformatf("v%0d_par", i), 32'(bus_a.out_par), 32'(v.exp_par));
            check($sformatf("v%0d_comma", i), 32'(bus_a.out_comma), 32'(v.exp_comma));
`ifdef SER2PAR_ALIGN_ERRCNT_EN
            check($sformatf("v%0d_err", i), 32'(bus_a.err_cnt), 32'(v.exp_err));
`endif
        end

        // Reset asserted at bit 5 of a locked word: everything clears at once.
        send_a(10'(P10 >> 5), 5, 1'b0);
        check("mid_locked_before", 32'(bus_a.locked), 32'd1);
        check("mid_par_before", 32'(bus_a.out_par), 32'(P10));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_par", 32'(bus_a.out_par), 32'd0);
        check("mid_rst_valid", 32'(bus_a.out_valid), 32'd0);
        check("mid_rst_comma", 32'(bus_a.out_comma), 32'd0);
        check("mid_rst_locked", 32'(bus_a.locked), 32'd0);
        check("mid_rst_state", 32'(bus_a.state), 32'(ST_HUNT));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_a(C10, 10, 1'b0);
        send_a(C10, 10, 1'b0);
        send_a(C10, 10, 1'b0);
        check("relock_state", 32'(bus_a.state), 32'(ST_LOCKED));
        send_a(P10, 10, 1'b0);
        check("relock_valid", 32'(bus_a.out_valid), 32'd1);
        check("relock_par", 32'(bus_a.out_par), 32'(P10));

        // LSB-first 8-bit instance with comma 0xBC.
        send_b(8'hBC);
        check("b_comma1_state", 32'(bus_b.state), 32'(ST_CHECK));
        send_b(8'hBC);
        check("b_comma2_state", 32'(bus_b.state), 32'(ST_CHECK));
        send_b(8'hBC);
        check("b_comma3_state", 32'(bus_b.state), 32'(ST_LOCKED));
        check("b_comma3_locked", 32'(bus_b.locked), 32'd1);
        exp_q.push_back(8'hA5);
        stream_b(8'hA5, 1'b0, "b_a5");
        exp_q.push_back(8'h3C);
        stream_b(8'h3C, 1'b0, "b_3c");
        exp_q.push_back(8'hBC);
        stream_b(8'hBC, 1'b1, "b_bc");
        check("b_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
